mux16_scan_ctrl: RTL
====================

Name: mux16_scan_ctrl

Overview:
- Sequencer that owns the 4-bit select of the 16:1 mux tree (`mux16`: four `mux` leaves plus one final `mux`).
- Steps the select through the enabled channels, holds each select for a settle interval, then samples the mux output.
- Assembles a 16-bit snapshot of the mux inputs.
- Supports single-sweep and continuous modes, with a start/busy/done handshake toward the host logic.

Parameters:
SETTLE_CYC, 2, cycles `sel` is held stable before sampling; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  sweep request; acted on only in IDLE
cont  input  1  continuous mode; latched when start is accepted
stop  input  1  end continuous operation after the current sweep
ch_mask  input  16  enabled channels; bit n = mux input n; latched when start is accepted
mux_out  input  1  output f of the 16:1 mux
sel  output  4  drives mux sw[3:0]
busy  output  1  high whenever state != IDLE
sample_vld  output  1  one-cycle pulse: a channel was sampled
sample_ch  output  4  channel index of the current sample
sample_bit  output  1  sampled value
scan_data  output  16  snapshot; bit n = last sample of channel n
done  output  1  one-cycle pulse at the end of each sweep

Behaviour:
- Reset (rst high at a clk edge, in any state):
  - state=IDLE.
  - sel=0, busy=0, sample_vld=0, sample_ch=0, sample_bit=0, scan_data=0, done=0.
  - Latched mask=0, latched cont=0, stop_pending=0.
  - Reset mid-sweep aborts the sweep; no done pulse is produced.
- All outputs are registered.
- Start acceptance:
  - In IDLE, start=1 with ch_mask!=0 latches ch_mask and cont, clears scan_data to 0, sets ptr=0, and moves to SEEK.
  - start with ch_mask==0 is ignored: no state change, no done pulse.
  - start while busy is ignored.
- States:
  - IDLE: sel holds its last value.
  - SEEK (1 cycle): picks the lowest enabled channel idx >= ptr. sel<=idx, settle counter<=SETTLE_CYC-1, next state SETTLE. A SEEK is only entered when such a channel exists.
  - SETTLE (SETTLE_CYC cycles): sel held stable; counter decrements each cycle; leaves for SAMPLE when counter==0.
  - SAMPLE (1 cycle): at its closing edge:
    - scan_data[sel]<=mux_out, sample_bit<=mux_out, sample_ch<=sel, sample_vld<=1 for exactly the next cycle.
    - If an enabled channel > sel exists: ptr<=sel+1, go to SEEK.
    - Otherwise the sweep is complete: done<=1 for one cycle, coincident with the final sample_vld.
    - After a completed sweep: if latched cont=1 and stop_pending=0, ptr<=0 and go to SEEK; otherwise go to IDLE and clear stop_pending.
- Timing:
  - Per-channel cost is SETTLE_CYC+2 cycles.
  - For k enabled channels, done is high exactly (SETTLE_CYC+2)*k+1 cycles after the cycle in which start was sampled.
- stop:
  - stop=1 in any busy cycle sets stop_pending; the current sweep still completes fully.
  - stop in IDLE has no effect.
- scan_data:
  - Bits of disabled channels remain 0 for the whole operation.
  - In continuous mode, enabled bits are overwritten sweep by sweep; there is no clear between sweeps.
- Channel 15 handling: the ptr+1 calculation saturates logically. Once channel 15 is sampled, the sweep is complete; ptr never wraps to 0 within a sweep.
- Simultaneous events: start and stop in the same IDLE cycle means the start is accepted and stop_pending is not set (stop is ignored in IDLE).

Decomposition:
- Shared package mux16_scan_pkg holds:
  - NCH=16 and SEL_W=4.
  - State enum {IDLE, SEEK, SETTLE, SAMPLE}.
- One sub-module, mux_next_ch: combinational masked priority encoder.
  - Inputs: 16-bit mask, 4-bit ptr.
  - Outputs: found and idx, where idx is the lowest set bit with index >= ptr.
  - Used both in SEEK and for the "more channels" check in SAMPLE.

Test Plan:
- Reset/idle: assert rst for 2 cycles mid-sweep -> all outputs 0 the next cycle, state IDLE, no done; start with ch_mask=0 -> busy remains 0.
- Single sweep: SETTLE_CYC=2, ch_mask=16'h0005, mux inputs drive ch0=1 and ch2=0; start in cycle 0 ->
  - sel=0 in cycles 2-3; sample_vld in cycle 5 with ch=0, bit=1.
  - sel=2 in cycles 6-7; sample_vld plus done in cycle 9 with ch=2, bit=0.
  - scan_data=16'h0001; busy falls in cycle 9.
- Full mask: ch_mask=16'hFFFF, mux inputs=16'hA5C3 -> 16 samples in ascending channel order, scan_data=16'hA5C3, done at cycle 65.
- Channel 15 boundary: ch_mask=16'h8001 -> samples on ch0 then ch15, then done; no further SEEK; ptr does not wrap.
- Continuous mode plus stop: cont=1, ch_mask=16'h0010; change mux input 4 between sweeps ->
  - done pulses every 4 cycles and scan_data[4] tracks the input.
  - stop asserted mid-sweep -> exactly one further done, then IDLE.
- Ignored requests: a start pulse while busy -> timing and ch_mask latch unchanged; a settle of SETTLE_CYC=1 gives a per-channel period of 3 cycles.

Source files
------------

// File: rtl/mux16_scan_pkg.sv
// Shared constants and state encoding for the 16:1 mux scan sequencer.
package mux16_scan_pkg;

   localparam int NCH   = 16;
   localparam int SEL_W = 4;

   // Fixed state codes, kept as plain constants so older code can keep using them.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEEK   = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_SAMPLE = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      SEEK   = ST_SEEK,
      SETTLE = ST_SETTLE,
      SAMPLE = ST_SAMPLE
   } state_e;

endpackage

// File: rtl/mux_next_ch.sv
// Masked priority encoder: lowest enabled channel at or above ptr.
module mux_next_ch
   import mux16_scan_pkg::*;
(
   input  logic [NCH-1:0]   mask,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   // Scan from the top down so the lowest qualifying channel is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(ptr))) begin
            found = 1'b1;
            idx   = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Scan sequencer for the 16:1 mux tree: walks the enabled channels, lets each
// select settle, samples the mux output and builds a 16-bit snapshot.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; sel keeps its last value
// SEEK   | drive sel to the next enabled channel, load settle counter
// SETTLE | hold sel while the settle down-counter runs to zero
// SAMPLE | capture mux_out; next channel, next sweep, or back to IDLE
module mux16_scan_ctrl
   import mux16_scan_pkg::*;
#(
   parameter int SETTLE_CYC = 2
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             stop,
   input  logic [NCH-1:0]   ch_mask,
   input  logic             mux_out,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             sample_vld,
   output logic [SEL_W-1:0] sample_ch,
   output logic             sample_bit,
   output logic [NCH-1:0]   scan_data,
   output logic             done
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

   logic [1:0]       state;
   logic [NCH-1:0]   mask_q;
   logic             cont_q;
   logic             stop_pend;
   logic [SEL_W-1:0] ptr;
   logic [3:0]       cnt;

   logic [SEL_W-1:0] enc_ptr;
   logic             enc_found;
   logic [SEL_W-1:0] enc_idx;
   logic             more_ch;
   logic             keep_going;

   // One encoder serves both SEEK (search from ptr) and SAMPLE (any channel above sel?).
   always_comb begin
      enc_ptr = (state == ST_SAMPLE) ? (sel + 4'd1) : ptr;
   end

   mux_next_ch u_next_ch (
      .mask  (mask_q),
      .ptr   (enc_ptr),
      .found (enc_found),
      .idx   (enc_idx)
   );

   // sel+1 wraps at channel 15, so channel 15 always ends the sweep.
   always_comb begin
      more_ch    = enc_found && (sel != 4'hF);
      keep_going = cont_q && !stop_pend && !stop;
   end

   // Sequencer state, select, settle timer and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         mask_q     <= '0;
         cont_q     <= 1'b0;
         stop_pend  <= 1'b0;
         ptr        <= '0;
         cnt        <= '0;
         sel        <= '0;
         busy       <= 1'b0;
         sample_vld <= 1'b0;
         sample_ch  <= '0;
         sample_bit <= 1'b0;
         scan_data  <= '0;
         done       <= 1'b0;
      end else begin
         sample_vld <= 1'b0;
         done       <= 1'b0;

         if ((state != ST_IDLE) && stop) begin
            stop_pend <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (start && (ch_mask != '0)) begin
                  mask_q    <= ch_mask;
                  cont_q    <= cont;
                  scan_data <= '0;
                  ptr       <= '0;
                  busy      <= 1'b1;
                  state     <= ST_SEEK;
               end
            end

            ST_SEEK: begin
               sel   <= enc_idx;
               cnt   <= SETTLE_INIT;
               state <= ST_SETTLE;
            end

            ST_SETTLE: begin
               if (cnt == 4'd0) begin
                  state <= ST_SAMPLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            ST_SAMPLE: begin
               scan_data[sel] <= mux_out;
               sample_bit     <= mux_out;
               sample_ch      <= sel;
               sample_vld     <= 1'b1;
               if (more_ch) begin
                  ptr   <= sel + 4'd1;
                  state <= ST_SEEK;
               end else begin
                  done <= 1'b1;
                  if (keep_going) begin
                     ptr   <= '0;
                     state <= ST_SEEK;
                  end else begin
                     stop_pend <= 1'b0;
                     busy      <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
